// File: rtl/gate_test_sequencer_pkg.sv
// Shared types and constants for the gate test sequencer.
package gate_test_sequencer_pkg;

    localparam int unsigned LFSR_W   = 12;
    localparam int unsigned MISR_W   = 16;
    localparam int unsigned RESP_W   = 10;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned SETTLE_W = 4;

    // Feedback taps as bit masks: LFSR uses L[11],L[5],L[3],L[0]; MISR uses M[15],M[14],M[12],M[3].
    localparam logic [LFSR_W-1:0] LFSR_TAPS    = 12'h829;
    localparam logic [MISR_W-1:0] MISR_TAPS    = 16'hD008;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 12'h001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/gate_test_sequencer_if.sv
// Control, stimulus and result signals of the gate test sequencer.
interface gate_test_sequencer_if;
    import gate_test_sequencer_pkg::*;

    logic              start_i;
    logic              abort_i;
    logic [CNT_W-1:0]  num_patterns_i;
    logic [MISR_W-1:0] expected_i;
    logic [LFSR_W-1:0] pattern_o;
    logic [RESP_W-1:0] response_i;
    logic              capture_o;
    logic              busy_o;
    logic              done_o;
    logic [MISR_W-1:0] signature_o;
    logic              pass_o;

    modport master (
        output start_i, abort_i, num_patterns_i, expected_i, response_i,
        input  pattern_o, capture_o, busy_o, done_o, signature_o, pass_o
    );

    modport slave (
        input  start_i, abort_i, num_patterns_i, expected_i, response_i,
        output pattern_o, capture_o, busy_o, done_o, signature_o, pass_o
    );

endinterface

// File: rtl/gt_lfsr_misr.sv
// Pattern LFSR plus response-compacting MISR, stepped together once per capture.
module gt_lfsr_misr
    import gate_test_sequencer_pkg::*;
#(
    parameter int unsigned         L_WIDTH = LFSR_W,
    parameter logic [L_WIDTH-1:0]  L_TAPS  = LFSR_TAPS,
    parameter logic [L_WIDTH-1:0]  L_SEED  = DEFAULT_SEED,
    parameter int unsigned         M_WIDTH = MISR_W,
    parameter logic [M_WIDTH-1:0]  M_TAPS  = MISR_TAPS,
    parameter int unsigned         D_WIDTH = RESP_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lfsr_load_i,
    input  logic               misr_clear_i,
    input  logic               step_i,
    input  logic [D_WIDTH-1:0] data_i,
    output logic [L_WIDTH-1:0] lfsr_o,
    output logic [M_WIDTH-1:0] misr_next_c
);

    logic [L_WIDTH-1:0] lfsr_q, lfsr_d;
    logic [M_WIDTH-1:0] misr_q, misr_d;

    // Next-state: load/clear take priority over stepping.
    always_comb begin
        lfsr_d = lfsr_q;
        misr_d = misr_q;
        if (lfsr_load_i) begin
            lfsr_d = L_SEED;
        end else if (step_i) begin
            lfsr_d = {lfsr_q[L_WIDTH-2:0], ^(lfsr_q & L_TAPS)};
        end
        if (misr_clear_i) begin
            misr_d = '0;
        end else if (step_i) begin
            misr_d = {misr_q[M_WIDTH-2:0], ^(misr_q & M_TAPS)} ^ M_WIDTH'(data_i);
        end
    end

    // State registers; LFSR resets to the seed so pattern_o is defined in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= L_SEED;
            misr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            misr_q <= misr_d;
        end
    end

    assign lfsr_o      = lfsr_q;
    assign misr_next_c = misr_d;

endmodule

// File: rtl/gate_test_sequencer.sv
// Applies LFSR patterns to a gate model, compacts responses in a MISR, reports signature and pass.
module gate_test_sequencer
    import gate_test_sequencer_pkg::*;
#(
    parameter int unsigned        SETTLE_CYCLES = 2,
    parameter logic [LFSR_W-1:0]  LFSR_SEED     = DEFAULT_SEED
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gate_test_sequencer_if.slave  bus
);

    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

    state_e              state_q, state_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [MISR_W-1:0]   expected_q, expected_d;
    logic [MISR_W-1:0]   signature_q, signature_d;
    logic                pass_q, pass_d;
    logic                busy_q, busy_d;
    logic                capture_q, capture_d;
    logic                done_q, done_d;

    logic                lfsr_load, misr_clear, step;
    logic [LFSR_W-1:0]   lfsr_val;
    logic [MISR_W-1:0]   misr_next_c;

    gt_lfsr_misr #(
        .L_WIDTH (LFSR_W),
        .L_TAPS  (LFSR_TAPS),
        .L_SEED  (LFSR_SEED),
        .M_WIDTH (MISR_W),
        .M_TAPS  (MISR_TAPS),
        .D_WIDTH (RESP_W)
    ) u_lfsr_misr (
        .clk          (clk),
        .rst_n        (rst_n),
        .lfsr_load_i  (lfsr_load),
        .misr_clear_i (misr_clear),
        .step_i       (step),
        .data_i       (bus.response_i),
        .lfsr_o       (lfsr_val),
        .misr_next_c  (misr_next_c)
    );

    // Next-state and registered-output logic; outputs follow the state being entered.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        count_d      = count_q;
        expected_d   = expected_q;
        signature_d  = signature_q;
        pass_d       = pass_q;
        lfsr_load    = 1'b0;
        misr_clear   = 1'b0;
        step         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i) begin
                    expected_d = bus.expected_i;
                    misr_clear = 1'b1;
                    if (bus.num_patterns_i != '0) begin
                        state_d      = ST_SETTLE;
                        lfsr_load    = 1'b1;
                        count_d      = bus.num_patterns_i;
                        settle_cnt_d = SETTLE_LOAD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SETTLE: begin
                if (bus.abort_i) begin
                    state_d = ST_IDLE;
                end else if (settle_cnt_q == SETTLE_W'(1)) begin
                    state_d = ST_CAPTURE;
                end else begin
                    settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
                end
            end
            ST_CAPTURE: begin
                if (bus.abort_i) begin
                    state_d = ST_IDLE;
                end else begin
                    step    = 1'b1;
                    count_d = count_q - CNT_W'(1);
                    if (count_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = SETTLE_LOAD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Result is published on entry to DONE so it is visible alongside done_o.
        if (state_d == ST_DONE) begin
            signature_d = misr_next_c;
            pass_d      = (misr_next_c == expected_d);
        end

        busy_d    = (state_d == ST_SETTLE) || (state_d == ST_CAPTURE);
        capture_d = (state_d == ST_CAPTURE);
        done_d    = (state_d == ST_DONE);
    end

    // Control and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            count_q      <= '0;
            expected_q   <= '0;
            signature_q  <= '0;
            pass_q       <= 1'b0;
            busy_q       <= 1'b0;
            capture_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            count_q      <= count_d;
            expected_q   <= expected_d;
            signature_q  <= signature_d;
            pass_q       <= pass_d;
            busy_q       <= busy_d;
            capture_q    <= capture_d;
            done_q       <= done_d;
        end
    end

    assign bus.pattern_o   = lfsr_val;
    assign bus.capture_o   = capture_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.signature_o = signature_q;
    assign bus.pass_o      = pass_q;

endmodule
